rtc_match_irq: RTL and testbench
================================

// Module: rtc_match_irq
// PURPOSE
//  Match/interrupt stage directly downstream of the RTC update logic. Consumes the
//  updated RTC value and equivalent match value and detects the cycle the RTC value
//  steps onto the match value. Holds a raw interrupt latch, masks it, and drives the
//  registered RTCINTR. Blanks detection while a load/match write is being recomputed.
// PARAMETERS
//  DATA_W        32  width of RtcValue/MatchData
//  BLANK_CYCLES  4   cycles detection is suppressed after an RTCLR/RTCMR write; legal range 3..7
// PORTS
//  PCLK        in   1       APB clock; only clock
//  PRESET      in   1       synchronous, active-high reset
//  RtcValue    in   DATA_W  current RTC value from the update stage (registered there)
//  MatchData   in   DATA_W  equivalent match value from the update stage
//  RTCEn       in   1       RTC enable; 0 = no match events
//  WrenRTCLR   in   1       load register write strobe (1 cycle)
//  WrenRTCMR   in   1       match register write strobe (1 cycle)
//  WrenRTCICR  in   1       interrupt clear register write strobe
//  ClrData     in   1       PWDATA[0] accompanying WrenRTCICR; 1 = clear
//  IntMask     in   1       RTCIMSC bit; 1 = interrupt enabled
//  RawIntr     out  1       RTCRIS raw interrupt latch
//  MaskedIntr  out  1       RTCMIS = RawIntr & IntMask (combinational)
//  MissedMatch out  1       sticky: a match occurred while RawIntr already set
//  RTCINTR     out  1       registered interrupt to the system
// BEHAVIOUR
//  Reset (PRESET=1 at a PCLK edge): RawIntr=0, MissedMatch=0, RTCINTR=0, RtcPrev=0,
//   state=ST_BLANK, blank counter=BLANK_CYCLES. Reset mid-operation discards any pending
//   hit and any blanking in progress.
//  RtcPrev: register, loads RtcValue every cycle (including while blanking).
//  Hit (comb) = state==ST_ARMED & RTCEn & (RtcValue != RtcPrev) & (RtcValue == MatchData).
//   Static equality never fires; only a change of RtcValue onto MatchData fires.
//  State machine (ST_ARMED, ST_BLANK):
//   any state, WrenRTCLR|WrenRTCMR -> ST_BLANK, counter := BLANK_CYCLES (re-write reloads).
//   ST_BLANK: counter decrements each cycle; when counter==1 and no new write -> ST_ARMED.
//   ST_ARMED: stays until a write strobe. Write in same cycle as a Hit: Hit still counts.
//  RawIntr: Hit sets it at the end of the Hit cycle. Clear = WrenRTCICR & ClrData.
//   Simultaneous Hit and clear: set wins (RawIntr stays 1, MissedMatch unchanged).
//   WrenRTCICR with ClrData=0: no effect.
//  MissedMatch: set when Hit & RawIntr already 1 & no clear that cycle; cleared only by clear.
//  Latency: RtcValue first shows match value in cycle 0 -> RawIntr=1 in cycle 1 ->
//   RTCINTR=1 in cycle 2 (if IntMask=1). IntMask change reaches RTCINTR one cycle later.
//  RTCINTR <= RawIntr & IntMask each cycle (reset 0).
//  Wrap-around: RtcValue FFFF_FFFF -> 0000_0000 with MatchData=0 is a normal Hit.
//  RTCEn=0: no Hit; existing RawIntr holds until cleared. Update stage forces RtcValue=0;
//   the step to 0 does not fire even if MatchData==0.
//  Comparisons full DATA_W, unsigned equality only; no arithmetic in this block.
// STRUCTURE
//  Shared package rtc_pkg: state encodings ST_ARMED/ST_BLANK, RTC_DATA_W=32,
//   RTC_BLANK_DEFAULT=4, blank counter width (3 bits).
//  One sub-module: rtc_blank_timer (load on strobe, decrement, done flag); the rest
//   (edge/equality detect, latches, RTCINTR register) stays in rtc_match_irq.
// TESTING
//  1 Release reset, wait 4 cycles, MatchData=0x10, RtcValue 0x0F->0x10, IntMask=1 ->
//    RawIntr=1 next cycle, RTCINTR=1 the cycle after, MissedMatch=0.
//  2 RawIntr=1, RtcValue stepped onto MatchData again -> MissedMatch=1; ICR write
//    ClrData=1 -> both 0 next cycle; ICR with ClrData=0 -> no change.
//  3 WrenRTCMR pulse, Hit 2 cycles later -> no RawIntr; Hit at cycle BLANK_CYCLES+1
//    after strobe -> RawIntr=1; second strobe during blank restarts the 4-cycle window.
//  4 Hit and clear in same cycle with RawIntr=0 -> RawIntr=1; RawIntr=1 & clear only -> 0.
//  5 MatchData=0, RtcValue FFFF_FFFF->0 with RTCEn=1 -> fire; RTCEn=0 and RtcValue
//    forced 5->0 -> no fire; MatchData==RtcValue held constant 10 cycles -> no fire.
//  6 IntMask=0 during Hit -> RawIntr=1, MaskedIntr=0, RTCINTR=0; IntMask->1 -> RTCINTR=1
//    one cycle later; PRESET asserted with RawIntr=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared state encodings and sizing for the RTC match/interrupt stage
package rtc_pkg;
    localparam int RTC_DATA_W        = 32;
    localparam int RTC_BLANK_DEFAULT = 4;
    localparam int RTC_BLANK_W       = 3;
    typedef enum logic {ST_ARMED = 1'b0, ST_BLANK = 1'b1} rtc_state_t;
endpackage

// File: rtl/rtc_blank_timer.sv
// rtc_blank_timer: reloadable down-counter flagging the last cycle of a blanking window
module rtc_blank_timer
    import rtc_pkg::*;
#(
    parameter int BLANK_CYCLES = RTC_BLANK_DEFAULT
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic load,
    output logic done
);
    logic [RTC_BLANK_W-1:0] cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET || load) cnt <= RTC_BLANK_W'(BLANK_CYCLES);
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign done = (cnt == RTC_BLANK_W'(1));
endmodule

// File: rtl/rtc_match_irq.sv
// rtc_match_irq: detects RtcValue stepping onto MatchData and drives the RTC interrupt
module rtc_match_irq
    import rtc_pkg::*;
#(
    parameter int DATA_W       = RTC_DATA_W,
    parameter int BLANK_CYCLES = RTC_BLANK_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [DATA_W-1:0] RtcValue,
    input  logic [DATA_W-1:0] MatchData,
    input  logic              RTCEn,
    input  logic              WrenRTCLR,
    input  logic              WrenRTCMR,
    input  logic              WrenRTCICR,
    input  logic              ClrData,
    input  logic              IntMask,
    output logic              RawIntr,
    output logic              MaskedIntr,
    output logic              MissedMatch,
    output logic              RTCINTR
);
    rtc_state_t        state, state_nxt;
    logic [DATA_W-1:0] rtc_prev;
    logic              wr, blank_done, hit, clr;

    assign wr  = WrenRTCLR | WrenRTCMR;
    assign clr = WrenRTCICR & ClrData;
    // Only a change of RtcValue onto the match value fires, never static equality
    assign hit = (state == ST_ARMED) & RTCEn & (RtcValue != rtc_prev) & (RtcValue == MatchData);
    assign MaskedIntr = RawIntr & IntMask;

    rtc_blank_timer #(.BLANK_CYCLES(BLANK_CYCLES)) u_blank (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .load  (wr),
        .done  (blank_done)
    );

    always_comb begin
        state_nxt = wr ? ST_BLANK : (state == ST_BLANK && blank_done) ? ST_ARMED : state;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= ST_BLANK;
            rtc_prev    <= '0;
            RawIntr     <= 1'b0;
            MissedMatch <= 1'b0;
            RTCINTR     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rtc_prev    <= RtcValue;
            RawIntr     <= hit | (RawIntr & ~clr);
            // A clear coinciding with a hit leaves the missed flag untouched
            MissedMatch <= (clr & ~hit) ? 1'b0 : (MissedMatch | (hit & RawIntr & ~clr));
            RTCINTR     <= RawIntr & IntMask;
        end
    end
endmodule

// File: tb/tb_rtc_match_irq.sv
// tb_rtc_match_irq: directed checks of match detection, blanking, clear and masking
module tb_rtc_match_irq;
    logic        PCLK = 1'b0;
    logic        PRESET, RTCEn, WrenRTCLR, WrenRTCMR, WrenRTCICR, ClrData, IntMask;
    logic [31:0] RtcValue, MatchData;
    logic        RawIntr, MaskedIntr, MissedMatch, RTCINTR;
    int          checks = 0;
    int          errors = 0;

    rtc_match_irq dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .RtcValue   (RtcValue),
        .MatchData  (MatchData),
        .RTCEn      (RTCEn),
        .WrenRTCLR  (WrenRTCLR),
        .WrenRTCMR  (WrenRTCMR),
        .WrenRTCICR (WrenRTCICR),
        .ClrData    (ClrData),
        .IntMask    (IntMask),
        .RawIntr    (RawIntr),
        .MaskedIntr (MaskedIntr),
        .MissedMatch(MissedMatch),
        .RTCINTR    (RTCINTR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic clear_irq();
        WrenRTCICR = 1'b1;
        ClrData    = 1'b1;
        step();
        WrenRTCICR = 1'b0;
        ClrData    = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; RTCEn = 1'b1; WrenRTCLR = 1'b0; WrenRTCMR = 1'b0;
        WrenRTCICR = 1'b0; ClrData = 1'b0; IntMask = 1'b1;
        RtcValue = 32'h0; MatchData = 32'h0;
        step(); step();
        chk("rst_raw", RawIntr, 0);
        chk("rst_missed", MissedMatch, 0);
        chk("rst_intr", RTCINTR, 0);
        chk("rst_masked", MaskedIntr, 0);
        PRESET = 1'b0;
        repeat (4) step();

        // 1: basic step onto match and latency
        MatchData = 32'h10; RtcValue = 32'h0F; step();
        RtcValue = 32'h10; step();
        chk("t1_raw", RawIntr, 1);
        chk("t1_masked", MaskedIntr, 1);
        chk("t1_intr_c1", RTCINTR, 0);
        step();
        chk("t1_intr_c2", RTCINTR, 1);
        chk("t1_missed", MissedMatch, 0);

        // 2: missed match, clear, ClrData=0 no-op
        RtcValue = 32'h11; step();
        RtcValue = 32'h10; step();
        chk("t2_missed", MissedMatch, 1);
        clear_irq();
        chk("t2_clr_raw", RawIntr, 0);
        chk("t2_clr_missed", MissedMatch, 0);
        RtcValue = 32'h11; step();
        RtcValue = 32'h10; step();
        chk("t2_reraw", RawIntr, 1);
        WrenRTCICR = 1'b1; ClrData = 1'b0; step();
        WrenRTCICR = 1'b0;
        chk("t2_noclr", RawIntr, 1);
        clear_irq();
        chk("t2_clr2", RawIntr, 0);

        // 3: blanking after match-register write
        RtcValue = 32'h11; WrenRTCMR = 1'b1; step();
        WrenRTCMR = 1'b0; step();
        RtcValue = 32'h10; step();
        chk("t3_blank_c2", RawIntr, 0);
        RtcValue = 32'h11; step();
        step();
        RtcValue = 32'h10; step();
        chk("t3_armed_c5", RawIntr, 1);
        clear_irq();
        // second strobe restarts the window
        RtcValue = 32'h11; WrenRTCLR = 1'b1; step();
        WrenRTCLR = 1'b0; step();
        WrenRTCLR = 1'b1; step();
        WrenRTCLR = 1'b0; step(); step(); step();
        RtcValue = 32'h10; step();
        chk("t3_restart_c4", RawIntr, 0);
        RtcValue = 32'h11; step();
        RtcValue = 32'h10; step();
        chk("t3_restart_arm", RawIntr, 1);
        clear_irq();

        // 4: hit and clear together, set wins
        RtcValue = 32'h11; step();
        RtcValue = 32'h10; WrenRTCICR = 1'b1; ClrData = 1'b1; step();
        chk("t4_setwins", RawIntr, 1);
        chk("t4_missed", MissedMatch, 0);
        step();
        WrenRTCICR = 1'b0; ClrData = 1'b0;
        chk("t4_clr", RawIntr, 0);

        // 5: wrap-around, disabled, static equality
        MatchData = 32'h0; RtcValue = 32'hFFFF_FFFF; step();
        RtcValue = 32'h0; step();
        chk("t5_wrap", RawIntr, 1);
        clear_irq();
        RTCEn = 1'b0; RtcValue = 32'h5; step();
        RtcValue = 32'h0; step();
        chk("t5_dis", RawIntr, 0);
        RTCEn = 1'b1;
        repeat (10) step();
        chk("t5_static", RawIntr, 0);

        // 6: masking and reset with pending interrupt
        IntMask = 1'b0; MatchData = 32'h20; RtcValue = 32'h1F; step();
        RtcValue = 32'h20; step();
        chk("t6_raw", RawIntr, 1);
        chk("t6_masked0", MaskedIntr, 0);
        step();
        chk("t6_intr0", RTCINTR, 0);
        IntMask = 1'b1; #1;
        chk("t6_masked1", MaskedIntr, 1);
        chk("t6_intr_pre", RTCINTR, 0);
        step();
        chk("t6_intr1", RTCINTR, 1);
        PRESET = 1'b1; step();
        chk("t6_rst_raw", RawIntr, 0);
        chk("t6_rst_intr", RTCINTR, 0);
        chk("t6_rst_masked", MaskedIntr, 0);
        chk("t6_rst_missed", MissedMatch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
